mul_seq_ctrl: RTL and testbench
===============================

MUL_SEQ_CTRL -- requirements
Module: mul_seq_ctrl

Interface
REQ-001 Parameter: ZERO_SHORTCUT, default 1, meaning: when 1, an operand of zero completes without running the iteration loop.
REQ-002 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: start  input  1  request to begin a multiply; sampled on clk rising edge.
REQ-005 Port: op_a  input  32  unsigned multiplicand; sampled with an accepted start.
REQ-006 Port: op_b  input  32  unsigned multiplier; sampled with an accepted start.
REQ-007 Port: busy  output  1  high in RUN and DONE states.
REQ-008 Port: done  output  1  one-cycle pulse; high only in the DONE state.
REQ-009 Port: product  output  64  registered result {hi,lo} of the last completed multiply.

Function
REQ-010 The block SHALL contain exactly one instance of the team's 32-bit adder block (ports a, b, cin, sum, cout) as its only arithmetic resource, with cin tied to 0.
REQ-011 The block SHALL implement an unsigned 32x32->64 shift-and-add multiply.
REQ-012 The FSM SHALL have exactly three states, IDLE, RUN and DONE, registered and binary encoded.
REQ-013 In IDLE, start=1 SHALL be accepted at that edge: latch mcand<=op_a, lo<=op_b, hi<=0, cnt<=0.
REQ-014 On acceptance, the next state SHALL be RUN, except when ZERO_SHORTCUT=1 and (op_a==0 or op_b==0); in that case the next state SHALL be DONE, with product<=0 at the same edge.
REQ-015 Each RUN cycle, adder inputs SHALL be a=hi and b=(lo[0] ? mcand : 0).
REQ-016 At the RUN edge, updates SHALL be hi<={cout,sum[31:1]}, lo<={sum[0],lo[31:1]} and cnt<=cnt+1.
REQ-017 cnt SHALL be 6 bits; RUN SHALL execute exactly 32 iterations.
REQ-018 On the 32nd iteration edge (cnt==31), the state SHALL go to DONE and product SHALL load the post-shift {hi,lo}.
REQ-019 Latency: with acceptance at edge E0, iterations occur at edges E1..E32, done=1 from E32 to E33, and the state returns to IDLE at E33.
REQ-020 Zero-shortcut latency: done=1 from E0 to E1.
REQ-021 start while busy=1 SHALL be ignored, with no change to the latched operands or to product.
REQ-022 start held high continuously SHALL be accepted on each IDLE cycle, giving back-to-back operations separated by one IDLE cycle.
REQ-023 product SHALL change only at a DONE-entry edge or on reset, and SHALL otherwise hold.
REQ-024 Adder cout SHALL never be discarded; it SHALL be the MSB shifted into hi.
REQ-025 op_a and op_b SHALL be don't-care when no start is accepted.

Reset
REQ-026 rst=1 SHALL immediately force state=IDLE, busy=0, done=0, product=0, hi=0, lo=0, mcand=0 and cnt=0, without waiting for clk.
REQ-027 Reset asserted mid-RUN or in DONE SHALL abandon the operation with no done pulse.
REQ-028 After rst deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-029 Basic multiply: op_a=3, op_b=5, start for 1 cycle -> busy=1 for 33 cycles, done pulse 32 cycles after the acceptance edge, product=0x0000000000000F.
REQ-030 Carry path: op_a=0xFFFFFFFF, op_b=0xFFFFFFFF -> product=0xFFFFFFFE00000001.
REQ-031 Zero operand: op_a=0, op_b=0x1234 -> with ZERO_SHORTCUT=1, done on the cycle after acceptance with product=0; with ZERO_SHORTCUT=0, done after 32 cycles with product=0.
REQ-032 Start while busy: op_a=7, op_b=9 accepted, then start with op_a=2, op_b=2 pulsed at iteration 10 -> ignored, product=63, one done pulse only.
REQ-033 Reset mid-operation: rst pulsed at iteration 10 of 0x12345678 x 0x9ABCDEF0 -> busy=0, done=0, product=0 immediately, no done pulse; then 0x10000 x 0x10000 -> product=0x0000000100000000.
REQ-034 Continuous start: start held high with 6 x 7 -> done pulses every 34 cycles, product=42 each time.

Source files
------------

// File: rtl/mul_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mul_seq_ctrl (with add32 helper)
// Brief    : Unsigned 32x32->64 sequential shift-and-add multiplier with a
//            single shared 32-bit adder and a three-state control FSM.
// Revision : 1.0 - initial release
// ============================================================================

module add32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [32:0] w_full;

  assign w_full = {1'b0, a} + {1'b0, b} + {32'd0, cin};
  assign sum    = w_full[31:0];
  assign cout   = w_full[32];

endmodule

module mul_seq_ctrl #(
  parameter int ZERO_SHORTCUT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [63:0] product
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic       c_ZS       = (ZERO_SHORTCUT != 0);
  localparam logic [5:0] c_LAST_ITR = 6'd31;

  state_t      r_state;
  logic [31:0] r_mcand;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [5:0]  r_cnt;
  logic        r_busy;
  logic        r_done;
  logic [63:0] r_product;

  logic [31:0] w_addend;
  logic [31:0] w_sum;
  logic        w_cout;
  logic [31:0] w_hi_nxt;
  logic [31:0] w_lo_nxt;
  logic        w_zero_op;

  assign w_addend  = r_lo[0] ? r_mcand : 32'd0;
  assign w_zero_op = c_ZS && ((op_a == 32'd0) || (op_b == 32'd0));

  add32 u_add32 (
    .a    (r_hi),
    .b    (w_addend),
    .cin  (1'b0),
    .sum  (w_sum),
    .cout (w_cout)
  );

  // The adder carry becomes the new MSB of hi; sum LSB shifts into lo.
  assign w_hi_nxt = {w_cout, w_sum[31:1]};
  assign w_lo_nxt = {w_sum[0], r_lo[31:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_mcand   <= 32'd0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_cnt     <= 6'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_product <= 64'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mcand <= op_a;
            r_lo    <= op_b;
            r_hi    <= 32'd0;
            r_cnt   <= 6'd0;
            r_busy  <= 1'b1;
            if (w_zero_op) begin
              r_state   <= S_DONE;
              r_done    <= 1'b1;
              r_product <= 64'd0;
            end else begin
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          r_hi  <= w_hi_nxt;
          r_lo  <= w_lo_nxt;
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == c_LAST_ITR) begin
            r_state   <= S_DONE;
            r_done    <= 1'b1;
            r_product <= {w_hi_nxt, w_lo_nxt};
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_product;

endmodule
`default_nettype wire

// File: tb/tb_mul_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_seq_ctrl
// Brief    : Directed self-checking bench for mul_seq_ctrl (both shortcut modes).
// Revision : 1.0 - initial release
// ============================================================================

module tb_mul_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy, done;
  logic [63:0] product;
  logic        busy_n, done_n;
  logic [63:0] product_n;

  int n_checks = 0;
  int n_errors = 0;

  mul_seq_ctrl #(.ZERO_SHORTCUT(1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .product(product)
  );

  mul_seq_ctrl #(.ZERO_SHORTCUT(0)) u_dut_nz (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy_n), .done(done_n), .product(product_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%h exp=0x%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single-cycle start, then wait for done on the shortcut-enabled instance.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp);
    int n;
    int nb;
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    step();
    start = 1'b0;
    nb = busy ? 1 : 0;
    n  = 0;
    while (!done && n < 40) begin
      step();
      n++;
      if (busy) nb++;
    end
    chk({tag, "_lat"}, 64'(n), 64'd32);
    chk({tag, "_busycyc"}, 64'(nb), 64'd33);
    chk({tag, "_prod"}, product, exp);
    step();
    chk({tag, "_idle"}, {62'd0, busy, done}, 64'd0);
  endtask

  initial begin
    int n;
    int pulses;
    int prev;
    rst   = 1'b1;
    start = 1'b0;
    op_a  = 32'd0;
    op_b  = 32'd0;
    #1;
    chk("rst_out", {busy, done, product}, 66'd0);
    chk("rst_out_nz", {busy_n, done_n, product_n}, 66'd0);
    step();
    step();
    rst = 1'b0;
    step();

    run_op("basic", 32'd3, 32'd5, 64'h0000_0000_0000_000F);
    run_op("carry", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    run_op("mixed", 32'h0001_0003, 32'h0000_0100, 64'h0000_0000_0100_0300);

    // Zero operand: shortcut instance finishes at once, the other runs all 32.
    run_op("pre", 32'd3, 32'd5, 64'd15);
    op_a  = 32'd0;
    op_b  = 32'h1234;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("zs_done", {62'd0, busy, done}, 64'd3);
    chk("zs_prod", product, 64'd0);
    chk("nz_hold", product_n, 64'd15);
    step();
    chk("zs_end", {62'd0, busy, done}, 64'd0);
    n = 1;
    while (!done_n && n < 40) begin
      step();
      n++;
    end
    chk("nz_lat", 64'(n), 64'd32);
    chk("nz_prod", product_n, 64'd0);
    step();
    step();

    // Start while busy must be ignored.
    op_a  = 32'd7;
    op_b  = 32'd9;
    start = 1'b1;
    step();
    start = 1'b0;
    pulses = 0;
    prev   = 0;
    for (int k = 1; k <= 45; k++) begin
      if (k == 10) begin
        op_a  = 32'd2;
        op_b  = 32'd2;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      step();
      if (done) begin
        pulses++;
        prev = k;
      end
    end
    chk("sbusy_pulses", 64'(pulses), 64'd1);
    chk("sbusy_at", 64'(prev), 64'd32);
    chk("sbusy_prod", product, 64'd63);

    // Reset abandon mid-run.
    op_a  = 32'h1234_5678;
    op_b  = 32'h9ABC_DEF0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 10; k++) step();
    chk("mid_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("arst_out", {busy, done, product}, 66'd0);
    step();
    rst    = 1'b0;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (done) pulses++;
    end
    chk("arst_nodone", 64'(pulses), 64'd0);
    run_op("post_rst", 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000);

    // Continuous start: one IDLE cycle between ops, 34-cycle period.
    op_a   = 32'd6;
    op_b   = 32'd7;
    start  = 1'b1;
    pulses = 0;
    prev   = 0;
    for (int k = 1; k <= 105; k++) begin
      step();
      if (done) begin
        chk("cont_prod", product, 64'd42);
        if (pulses == 0) chk("cont_first", 64'(k), 64'd33);
        else chk("cont_period", 64'(k - prev), 64'd34);
        pulses++;
        prev = k;
      end
    end
    chk("cont_pulses", 64'(pulses), 64'd3);
    start = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      step();
      n++;
    end
    chk("cont_drain", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
